// File: rtl/tmds_pkg.sv
// Shared definitions for the per-channel TMDS encoder.
// Contents: symbol-type enum, disparity counter width, fixed control and
// guard-band symbols, and lookup helpers for control, TERC4 and guard symbols.
// All symbols are written bit 9 .. bit 0; bit 0 is serialised first.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } tmds_mode_e;

    // Running disparity is bounded to -16..+16, so six signed bits suffice.
    localparam int CNT_W = 6;

    localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

    localparam logic [9:0] GUARD_SYM_CH02 = 10'b1011001100;
    localparam logic [9:0] GUARD_SYM_CH1  = 10'b0100110011;

    // Number of ones in a byte.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Control-period symbol indexed by {c1,c0}.
    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'd0:    s = CTRL_SYM_00;
            2'd1:    s = CTRL_SYM_01;
            2'd2:    s = CTRL_SYM_10;
            2'd3:    s = CTRL_SYM_11;
            default: s = CTRL_SYM_00;
        endcase
        return s;
    endfunction

    // Data-island TERC4 symbol for a 4-bit nibble.
    function automatic logic [9:0] terc4_symbol(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            4'd15:   s = 10'b1011000011;
            default: s = 10'b1010011100;
        endcase
        return s;
    endfunction

    // Video guard band: channel 1 differs; any other index (including an
    // out-of-range one) falls back to the channel 0/2 symbol.
    function automatic logic [9:0] guard_symbol(input int channel);
        return (channel == 32'sd1) ? GUARD_SYM_CH1 : GUARD_SYM_CH02;
    endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Symbol-input / TMDS-output bundle of one encoder channel.
// master: symbol source (drives mode/data_in/ctrl/terc4_in, reads data_out).
// slave : the encoder.
interface tmds_encoder_if;
    logic [1:0] mode;      // 0 CTRL, 1 VIDEO, 2 TERC4, 3 GUARD
    logic [7:0] data_in;   // pixel byte
    logic [1:0] ctrl;      // {c1,c0}
    logic [3:0] terc4_in;  // data-island nibble
    logic [9:0] data_out;  // TMDS symbol, bit 0 first on the wire

    modport master (output mode, output data_in, output ctrl, output terc4_in,
                    input  data_out);
    modport slave  (input  mode, input  data_in, input  ctrl, input  terc4_in,
                    output data_out);
endinterface

// File: rtl/tmds_encoder_chk.sv
// Runtime checks for one TMDS encoder channel.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset of the encoder
//   cnt         running disparity register of the encoder
module tmds_encoder_chk #(
    parameter int CHANNEL = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic signed [5:0]      cnt
);

    a_channel_range: assert property (@(posedge clk) (CHANNEL <= 32'sd2))
        else $fatal(1, "tmds_encoder: CHANNEL %0d outside 0..2", CHANNEL);

    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
                                    ((cnt >= -6'sd16) && (cnt <= 6'sd16)))
        else $error("tmds_encoder: disparity %0d outside -16..16", cnt);

endmodule

// File: rtl/tmds_qm.sv
// Transition-minimisation stage of TMDS video encoding (combinational).
// Ports:
//   d    in  8  pixel byte
//   q_m  out 9  transition-minimised word; q_m[8]=1 marks the XOR chain
//   n1q  out 4  ones in q_m[7:0]
//   n0q  out 4  zeros in q_m[7:0]
module tmds_qm
    import tmds_pkg::*;
(
    input  logic [7:0] d,
    output logic [8:0] q_m,
    output logic [3:0] n1q,
    output logic [3:0] n0q
);

    logic [3:0] n1_s;
    logic       use_xnor_s;

    assign n1_s       = popcount8(d);
    // Dense bytes (and 4-ones bytes starting with 0) pick XNOR to cut transitions.
    assign use_xnor_s = (n1_s > 4'd4) || ((n1_s == 4'd4) && (d[0] == 1'b0));

    // Build the XOR/XNOR chain and count its ones.
    always_comb begin : p_chain
        logic [7:0] chain_v;
        chain_v    = 8'h00;
        chain_v[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            chain_v[i] = use_xnor_s ? ~(chain_v[i-1] ^ d[i]) : (chain_v[i-1] ^ d[i]);
        end
        q_m = {~use_xnor_s, chain_v};
        n1q = popcount8(chain_v);
        n0q = 4'd8 - popcount8(chain_v);
    end

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel TMDS encoder: pixel bytes, control bits, TERC4 nibbles or guard
// bands to 10-bit symbols for the 10:1 serializer. Two register stages, one
// symbol per clock, fixed 2-cycle latency for all modes.
// Ports:
//   clk    in  pixel clock (1x)
//   rst_n  in  asynchronous active-low reset (output returns to CTRL 00)
//   bus    tmds_encoder_if.slave: mode, data_in, ctrl, terc4_in in; data_out out
// Parameter CHANNEL (0..2) selects the video guard-band symbol.
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input logic           clk,
    input logic           rst_n,
    tmds_encoder_if.slave bus
);

    logic [8:0]              qm_s;
    logic [3:0]              n1q_s;
    logic [3:0]              n0q_s;

    tmds_mode_e              s1_mode_r;
    logic [1:0]              s1_ctrl_r;
    logic [3:0]              s1_terc4_r;
    logic [8:0]              s1_qm_r;
    logic [3:0]              s1_n1q_r;
    logic [3:0]              s1_n0q_r;

    logic [9:0]              data_out_r;
    logic signed [CNT_W-1:0] cnt_r;

    logic [9:0]              sym_s;
    logic signed [CNT_W-1:0] cnt_nxt_s;
    logic signed [CNT_W-1:0] diff_s;
    logic                    q8_s;
    logic [7:0]              q_s;

    tmds_qm u_qm (
        .d   (bus.data_in),
        .q_m (qm_s),
        .n1q (n1q_s),
        .n0q (n0q_s)
    );

    // Stage 1: capture the minimised word alongside the symbol-type inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mode_r  <= MODE_CTRL;
            s1_ctrl_r  <= 2'b00;
            s1_terc4_r <= 4'h0;
            s1_qm_r    <= 9'h000;
            s1_n1q_r   <= 4'd0;
            s1_n0q_r   <= 4'd0;
        end else begin
            s1_mode_r  <= tmds_mode_e'(bus.mode);
            s1_ctrl_r  <= bus.ctrl;
            s1_terc4_r <= bus.terc4_in;
            s1_qm_r    <= qm_s;
            s1_n1q_r   <= n1q_s;
            s1_n0q_r   <= n0q_s;
        end
    end

    assign q8_s   = s1_qm_r[8];
    assign q_s    = s1_qm_r[7:0];
    assign diff_s = $signed({2'b00, s1_n1q_r}) - $signed({2'b00, s1_n0q_r});

    // Stage 2 symbol selection and DC-balance update; non-video symbols clear cnt.
    always_comb begin
        sym_s     = CTRL_SYM_00;
        cnt_nxt_s = 6'sd0;
        case (s1_mode_r)
            MODE_VIDEO: begin
                if ((cnt_r == 6'sd0) || (diff_s == 6'sd0)) begin
                    // No bias either way: invert only on the XNOR path.
                    sym_s     = {~q8_s, q8_s, (q8_s ? q_s : ~q_s)};
                    cnt_nxt_s = cnt_r + (q8_s ? diff_s : -diff_s);
                end else if (((cnt_r > 6'sd0) && (diff_s > 6'sd0)) ||
                             ((cnt_r < 6'sd0) && (diff_s < 6'sd0))) begin
                    // Word would worsen the bias: send it inverted.
                    sym_s     = {1'b1, q8_s, ~q_s};
                    cnt_nxt_s = cnt_r + (q8_s ? 6'sd2 : 6'sd0) - diff_s;
                end else begin
                    sym_s     = {1'b0, q8_s, q_s};
                    cnt_nxt_s = cnt_r + diff_s - (q8_s ? 6'sd0 : 6'sd2);
                end
            end
            MODE_CTRL:  sym_s = ctrl_symbol(s1_ctrl_r);
            MODE_TERC4: sym_s = terc4_symbol(s1_terc4_r);
            MODE_GUARD: sym_s = guard_symbol(CHANNEL);
            default:    sym_s = CTRL_SYM_00;
        endcase
    end

    // Stage 2 register: output symbol and running disparity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= CTRL_SYM_00;
            cnt_r      <= 6'sd0;
        end else begin
            data_out_r <= sym_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    assign bus.data_out = data_out_r;

    tmds_encoder_chk #(.CHANNEL(CHANNEL)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt_r)
    );

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: channel 0 and channel 1 instances share
// one stimulus stream; a behavioural model queues expected symbols and a
// negedge monitor pops and compares, also decoding video symbols and tracking
// the running disparity of the emitted stream.
module tb_tmds_encoder;

    localparam logic [1:0] M_CTRL  = 2'd0;
    localparam logic [1:0] M_VIDEO = 2'd1;
    localparam logic [1:0] M_TERC4 = 2'd2;
    localparam logic [1:0] M_GUARD = 2'd3;

    localparam logic [9:0] CTRL_TAB [0:3] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    localparam logic [9:0] TERC_TAB [0:15] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct {
        logic [9:0] e0;
        logic [9:0] e1;
        bit         vid;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tmds_encoder_if if0();
    tmds_encoder_if if1();

    tmds_encoder #(.CHANNEL(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    tmds_encoder #(.CHANNEL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   model_disp = 0;
    int   act_disp = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference encoder from the TMDS rules: choose chain by byte density,
    // invert when the word would push the stream's disparity further off zero,
    // then accumulate ones-minus-zeros of the whole 10-bit symbol.
    function automatic logic [9:0] ref_encode(input logic [1:0] m, input logic [7:0] d,
                                              input logic [1:0] c, input logic [3:0] t,
                                              input int ch, inout int disp);
        logic [7:0] q;
        logic [9:0] s;
        bit use_xnor, q8, inv;
        int ones, bal;
        if (m == M_CTRL)  begin disp = 0; return CTRL_TAB[c]; end
        if (m == M_TERC4) begin disp = 0; return TERC_TAB[t]; end
        if (m == M_GUARD) begin disp = 0; return (ch == 1) ? 10'h133 : 10'h2CC; end
        ones = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ use_xnor;
        q8 = !use_xnor;
        bal = 2 * $countones(q) - 8;
        if (disp == 0 || bal == 0) inv = !q8;
        else inv = ((disp > 0) == (bal > 0));
        s = {inv, q8, inv ? ~q : q};
        disp += 2 * $countones(s) - 10;
        return s;
    endfunction

    // Independent TMDS decoder for round-trip checking.
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] w, d;
        w = s[9] ? ~s[7:0] : s[7:0];
        d[0] = w[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
        return d;
    endfunction

    task automatic drive(input logic [1:0] m, input logic [7:0] d,
                         input logic [1:0] c, input logic [3:0] t);
        exp_t e;
        int dcopy;
        if0.mode = m; if0.data_in = d; if0.ctrl = c; if0.terc4_in = t;
        if1.mode = m; if1.data_in = d; if1.ctrl = c; if1.terc4_in = t;
        dcopy = model_disp;
        e.e1  = ref_encode(m, d, c, t, 1, dcopy);
        e.e0  = ref_encode(m, d, c, t, 0, model_disp);
        e.vid = (m == M_VIDEO);
        e.d   = d;
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d,
                        input logic [1:0] c, input logic [3:0] t);
        drive(m, d, c, t);
        @(posedge clk);
        #1;
    endtask

    // The two symbols already in the pipeline after reset are CTRL 00.
    task automatic prime();
        exp_t e;
        sb.delete();
        e.e0 = 10'h354; e.e1 = 10'h354; e.vid = 1'b0; e.d = 8'h00;
        sb.push_back(e);
        sb.push_back(e);
        model_disp = 0;
        act_disp = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL scoreboard_underflow: output with no expected entry at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("dout_ch0", if0.data_out, mon_e.e0);
                check("dout_ch1", if1.data_out, mon_e.e1);
                if (mon_e.vid) begin
                    check("decode", {2'b00, decode(if0.data_out)}, {2'b00, mon_e.d});
                    act_disp += 2 * $countones(if0.data_out) - 10;
                    total_cnt++;
                    if (act_disp >= -16 && act_disp <= 16) pass_cnt++;
                    else $display("FAIL disparity_bound: got %0d required -16..16", act_disp);
                end else begin
                    act_disp = 0;
                end
            end
        end
    end

    initial begin
        int r;
        int wait_n;
        if0.mode = M_CTRL; if0.data_in = 8'h00; if0.ctrl = 2'b00; if0.terc4_in = 4'h0;
        if1.mode = M_CTRL; if1.data_in = 8'h00; if1.ctrl = 2'b00; if1.terc4_in = 4'h0;

        // Outputs held at CTRL 00 while in reset.
        repeat (3) begin
            @(negedge clk);
            check("reset_ch0", if0.data_out, 10'h354);
            check("reset_ch1", if1.data_out, 10'h354);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prime();
        mon_en = 1'b1;

        // Directed: video zeros after control, 0xFF then CTRL 01, ctrl sweep.
        send(M_CTRL, 8'h00, 2'b00, 4'h0);
        repeat (3) send(M_VIDEO, 8'h00, 2'b00, 4'h0);
        send(M_CTRL, 8'h00, 2'b00, 4'h0);
        send(M_VIDEO, 8'hFF, 2'b00, 4'h0);
        send(M_CTRL, 8'h00, 2'b01, 4'h0);
        for (int c = 0; c < 4; c++) send(M_CTRL, 8'h00, 2'(c), 4'h0);
        for (int t = 0; t < 16; t++) send(M_TERC4, 8'h00, 2'b00, 4'(t));
        send(M_GUARD, 8'h00, 2'b00, 4'h0);
        send(M_GUARD, 8'h00, 2'b00, 4'h0);
        send(M_VIDEO, 8'h0F, 2'b00, 4'h0);
        send(M_VIDEO, 8'h10, 2'b00, 4'h0);
        send(M_VIDEO, 8'hA5, 2'b00, 4'h0);

        // Random mix, weighted toward video so the disparity wanders.
        for (int n = 0; n < 10000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) send(M_VIDEO, 8'($urandom), 2'($urandom), 4'($urandom));
            else if (r == 7) send(M_CTRL, 8'($urandom), 2'($urandom), 4'($urandom));
            else if (r == 8) send(M_TERC4, 8'($urandom), 2'($urandom), 4'($urandom));
            else send(M_GUARD, 8'($urandom), 2'($urandom), 4'($urandom));
        end

        // Reset in the middle of a video run.
        repeat (5) send(M_VIDEO, 8'($urandom), 2'b00, 4'h0);
        mon_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ch0", if0.data_out, 10'h354);
        check("async_reset_ch1", if1.data_out, 10'h354);
        @(posedge clk);
        #1;
        check("reset_hold_ch0", if0.data_out, 10'h354);
        rst_n = 1'b1;
        prime();
        mon_en = 1'b1;
        for (int n = 0; n < 50; n++) send(M_VIDEO, 8'($urandom), 2'b00, 4'h0);
        send(M_CTRL, 8'h00, 2'b00, 4'h0);

        // Drain the pipeline with a bounded wait.
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 10) begin
            @(posedge clk);
            wait_n++;
        end
        mon_en = 1'b0;
        total_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL drain_timeout: got %0d pending entries required 0", sb.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
